// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial comparator and its benches.
package cmp_pkg;

    localparam int CMP_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cmp_state_e;

    // Result encoding as {eq, gt, lt}; exactly one bit set after a compare.
    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/cmp_bit_shifter.sv
// Paired operand register: parallel load, then left shift with zero fill so
// both MSBs can be compared one bit per clock.
module cmp_bit_shifter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_msb,
    output logic             b_msb
);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
        end else if (shift) begin
            a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh <= {b_sh[WIDTH-2:0], 1'b0};
        end
    end

    assign a_msb = a_sh[WIDTH-1];
    assign b_msb = b_sh[WIDTH-1];

endmodule

// File: rtl/serial_cmp6.sv
// Bit-serial MSB-first unsigned comparator with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; last result held on s/eq/gt/lt/nbits
//   SHIFT | comparing one MSB pair per clock until a difference or the LSB
module serial_cmp6
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       s,
    output logic                       eq,
    output logic                       gt,
    output logic                       lt,
    output logic [$clog2(WIDTH+1)-1:0] nbits
);

    localparam int NBW = $clog2(WIDTH + 1);
    localparam logic [NBW-1:0] CNT_LAST = NBW'(WIDTH - 1);
    localparam logic [NBW-1:0] NB_FULL  = NBW'(WIDTH);

    cmp_state_e     state_q, state_d;
    logic [NBW-1:0] cnt_q, cnt_d;
    logic           busy_d, done_d, s_d, eq_d, gt_d, lt_d;
    logic [NBW-1:0] nbits_d;
    logic           load, shift;
    logic           a_msb, b_msb;

    cmp_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .a     (a),
        .b     (b),
        .a_msb (a_msb),
        .b_msb (b_msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            nbits   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            s       <= s_d;
            eq      <= eq_d;
            gt      <= gt_d;
            lt      <= lt_d;
            nbits   <= nbits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        s_d     = s;
        eq_d    = eq;
        gt_d    = gt;
        lt_d    = lt;
        nbits_d = nbits;
        load    = 1'b0;
        shift   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    s_d     = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    nbits_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (a_msb != b_msb) begin
                    // First differing bit decides the ordering outright.
                    s_d     = 1'b1;
                    gt_d    = a_msb;
                    lt_d    = b_msb;
                    nbits_d = cnt_q + 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    eq_d    = 1'b1;
                    nbits_d = NB_FULL;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_cmp6.sv
// Scoreboard bench for serial_cmp6: directed compares, each checked on its done pulse.
module tb_serial_cmp6;
    import cmp_pkg::*;

    localparam int W   = CMP_WIDTH;
    localparam int NBW = $clog2(W + 1);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic           s;
    logic           eq;
    logic           gt;
    logic           lt;
    logic [NBW-1:0] nbits;

    serial_cmp6 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt),
        .nbits (nbits)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   res;
        int           nb;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the parallel XOR/OR inequality comparator.
    function automatic logic ref_ne(input logic [W-1:0] x, input logic [W-1:0] y);
        return |(x ^ y);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 required no pending compare (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("eq",      32'(eq), 32'(mon_e.res[2]));
                chk("gt",      32'(gt), 32'(mon_e.res[1]));
                chk("lt",      32'(lt), 32'(mon_e.res[0]));
                chk("s",       32'(s),  32'(mon_e.res != EQ));
                chk("s_ref",   32'(s),  32'(ref_ne(mon_e.a, mon_e.b)));
                chk("nbits",   32'(nbits), 32'(mon_e.nb));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called just after a negedge; start is accepted on the following posedge.
    task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic push, input logic [2:0] res,
                               input int nb, input int lat);
        exp_t e;
        a     = va;
        b     = vb;
        start = 1'b1;
        if (push) begin
            e.a   = va;
            e.b   = vb;
            e.res = res;
            e.nb  = nb;
            e.lat = lat;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done in %0d cycles required done", budget);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_s"},     32'(s),     32'd0);
        chk({tag, "_eq"},    32'(eq),    32'd0);
        chk({tag, "_gt"},    32'(gt),    32'd0);
        chk({tag, "_lt"},    32'(lt),    32'd0);
        chk({tag, "_nbits"}, 32'(nbits), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("idle");

        // MSB difference, single-cycle compare; result must hold afterwards.
        drive_start(6'b101010, 6'b010101, 1'b1, GT, 1, 1);
        wait_done(10);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("gt_held",        32'(gt),   32'd1);
        chk("nbits_held",     32'(nbits), 32'd1);

        // Only the LSB differs.
        drive_start(6'b100110, 6'b100111, 1'b1, LT, 6, 6);
        wait_done(10);

        // Equal operands back-to-back, second start in the done cycle.
        @(negedge clk);
        drive_start(6'b111111, 6'b111111, 1'b1, EQ, 6, 6);
        wait_done(10);
        drive_start(6'b000000, 6'b000000, 1'b1, EQ, 6, 6);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(10);

        // Start while busy, with changed operands, must be ignored.
        @(negedge clk);
        drive_start(6'b110000, 6'b111000, 1'b1, LT, 3, 3);
        a     = '0;
        b     = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid", 32'(busy), 32'd1);
        wait_done(10);
        repeat (3) @(negedge clk);
        chk("no_retrigger_busy", 32'(busy), 32'd0);
        chk("lt_held",           32'(lt),   32'd1);

        // Reset mid-compare aborts with no done pulse.
        drive_start(6'b000001, 6'b000000, 1'b0, EQ, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_busy", 32'(busy), 32'd0);
        drive_start(6'b000001, 6'b000000, 1'b1, GT, 6, 6);
        wait_done(10);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_cmp6.md
Name: serial_cmp6

Overview:
Bit-serial magnitude/inequality comparator for two WIDTH-bit operands. It evaluates the pair MSB-first, one bit per clock, and stops at the first differing bit. Results are reported as s (different), eq, gt and lt, together with a one-cycle done pulse. It is the sequential, handshaked counterpart of the parallel XOR/OR inequality comparator, for datapaths where operands arrive with a start strobe and area is traded for latency.

Parameters:
- WIDTH, 6: operand width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- s  output  1  1 when A != B.
- eq  output  1  1 when A == B.
- gt  output  1  1 when A > B, unsigned.
- lt  output  1  1 when A < B, unsigned.
- nbits  output  $clog2(WIDTH+1)  number of bit positions examined in the last comparison (1..WIDTH).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset values:
  - State IDLE.
  - busy, done, s, eq, gt, lt = 0; nbits = 0.
  - Shift registers are cleared.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge T0:
  - Load a_sh<=a, b_sh<=b; cnt<=0; busy<=1.
  - Clear s, eq, gt, lt and nbits to 0.
  - Go to SHIFT.
- SHIFT, each edge: compare a_sh[WIDTH-1] with b_sh[WIDTH-1], and set cnt<=cnt+1.
  - Bits differ:
    - s<=1, gt<=a_sh[MSB], lt<=b_sh[MSB].
    - nbits<=cnt+1; done<=1; busy<=0.
    - Go to IDLE.
  - Bits equal and cnt==WIDTH-1:
    - eq<=1, nbits<=WIDTH; done<=1; busy<=0.
    - Go to IDLE.
  - Otherwise: shift a_sh and b_sh left by 1 (zero-fill) and stay in SHIFT.
- Latency:
  - First difference at bit k (MSB = WIDTH-1): done is high in the cycle after edge T0+(WIDTH-k).
  - Equal operands: done is high in the cycle after edge T0+WIDTH.
  - Range is 1..WIDTH cycles after acceptance.
- done is exactly one cycle wide. It is deasserted on the following edge unless a new result completes on that edge (impossible, since the minimum latency is 1).
- Result outputs hold their value from the done cycle until the next accepted start.
- Exactly one of eq, gt, lt is 1 after any completed comparison, and s == ~eq.
- start while busy=1 is ignored. The operands are not re-captured and there is no queuing.
- start in the same cycle as done is accepted, because busy is already 0. This makes back-to-back operation possible with one idle cycle per compare.
- a and b are don't-care except at the accepting edge. Changing them mid-operation has no effect.
- rst_n=0 mid-comparison:
  - Abort on that edge; all outputs take their reset values.
  - No done pulse is produced.
  - start is ignored on any edge where rst_n=0.

Decomposition:
- Shared package, cmp_pkg: state enum (IDLE, SHIFT), CMP_WIDTH=6 default, and result encoding constants (EQ, GT, LT) for benches.
- Natural sub-module: cmp_bit_shifter. It holds the paired WIDTH-bit load/shift register that exposes both MSBs. The FSM, counter and result registers stay in serial_cmp6.
- The existing combinational inequality comparator serves as the reference model in the bench: s must match it on every done.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges, start=0 -> busy=done=s=eq=gt=lt=0 and nbits=0.
- MSB difference: a=101010, b=010101, start 1 cycle -> done after 1 cycle; s=1, gt=1, lt=0, eq=0, nbits=1.
- LSB-only difference: a=100110, b=100111 -> done after 6 cycles; s=1, lt=1, gt=0, nbits=6.
- Equal operands: a=b=111111, then a=b=000000 back-to-back (start asserted in the done cycle) -> each finishes in 6 cycles with eq=1, s=0, nbits=6; the second start is accepted with no lost request.
- Ignored start and operand change: a=110000, b=111000; in cycle 2 assert start with a=b=000000 -> completes after 3 cycles with lt=1, s=1, nbits=3; the second start has no effect.
- Reset mid-operation: a=000001, b=000000, drive rst_n=0 at cycle 3 -> no done pulse; outputs 0; a fresh start then completes normally with gt=1, nbits=6.
